btn_input_ctrl: RTL and testbench

- Receive side of the push-button interface: takes the 5 raw `btn` lines driven into `cpu` and presents clean data to the MIPS core.
- Synchronises, debounces and edge-detects each line, then latches press events into sticky pending bits.
- The core reads those bits through a read-and-clear register port.
- Sits between the top-level `btn` pins and the CPU data-memory/IO decode, beside the VGA block.

---
 rtl/btn_input_ctrl.sv | 110 +++++++++++
 tb/tb_btn_input_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_input_ctrl.sv
// rtl/btn_input_ctrl.sv - push-button receive block: synchronise, debounce, edge-detect, sticky pending, read-and-clear port
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   btn        in   NBTN raw asynchronous button levels, 1 = pressed
//   rd_en      in   one-cycle read strobe from the CPU IO decode
//   rd_data    out  32-bit registered snapshot {15'b0, overflow, level[7:0], pending[7:0]}
//   rd_valid   out  high for the single cycle after rd_en
//   btn_level  out  NBTN debounced stable levels
//   irq        out  registered OR of the pending bits

module btn_input_ctrl #(
    parameter int NBTN            = 5,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn,
    input  logic            rd_en,
    output logic [31:0]     rd_data,
    output logic            rd_valid,
    output logic [NBTN-1:0] btn_level,
    output logic            irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0]  r_sync1;
    logic [NBTN-1:0]  r_sync2;
    logic [CNT_W-1:0] r_cnt [NBTN];
    logic [NBTN-1:0]  r_level;
    logic [NBTN-1:0]  r_pending;
    logic             r_ovf;
    logic [31:0]      r_rd_data;
    logic             r_rd_valid;
    logic             r_irq;

    logic [CNT_W-1:0] w_cnt_next [NBTN];
    logic [NBTN-1:0]  w_level_next;
    logic [NBTN-1:0]  w_press;
    logic [NBTN-1:0]  w_pending_next;
    logic             w_ovf_next;
    logic [31:0]      w_snapshot;

    // Per-bit debounce: the count runs only while the synchronised level
    // disagrees with the accepted level; any agreement restarts it.
    always_comb begin
        w_level_next = r_level;
        for (int i = 0; i < NBTN; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (r_sync2[i] == r_level[i]) begin
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == CNT_MAX) begin
                w_level_next[i] = r_sync2[i];
                w_cnt_next[i]   = '0;
            end else begin
                w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
            end
        end
    end

    // A press that lands on the same edge as a clearing read survives the
    // clear (set wins) and is reported by the next read instead; such a
    // press is never counted as an overflow.
    always_comb begin
        w_press        = w_level_next & ~r_level;
        w_pending_next = rd_en ? w_press : (r_pending | w_press);
        w_ovf_next     = rd_en ? 1'b0 : (r_ovf | (|(w_press & r_pending)));
        w_snapshot     = {15'b0, r_ovf, 8'(r_level), 8'(r_pending)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            for (int i = 0; i < NBTN; i++) begin
                r_cnt[i] <= '0;
            end
            r_level    <= '0;
            r_pending  <= '0;
            r_ovf      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_sync1    <= btn;
            r_sync2    <= r_sync1;
            for (int i = 0; i < NBTN; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_level    <= w_level_next;
            r_pending  <= w_pending_next;
            r_ovf      <= w_ovf_next;
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_snapshot;
            end
            // irq tracks the registered pending bits, so it trails them by one edge
            r_irq      <= |r_pending;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign btn_level = r_level;
    assign irq       = r_irq;

endmodule

// File: tb/tb_btn_input_ctrl.sv
// tb/tb_btn_input_ctrl.sv - self-checking bench for btn_input_ctrl against a sliding-window reference model

module tb_btn_input_ctrl;

    localparam int NB = 5;
    localparam int DC = 16;
    localparam int HD = DC + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn = '0;
    logic          rd_en = 1'b0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic [NB-1:0] btn_level;
    logic          irq;

    int errors = 0;
    int checks = 0;

    btn_input_ctrl #(.NBTN(NB), .DEBOUNCE_CYCLES(DC), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .btn_level (btn_level),
        .irq       (irq)
    );

    always #10 clk = ~clk;

    // Reference model: a level flips once the last DC synchronised samples
    // (raw samples two edges old) all disagree with it.
    logic [NB-1:0] m_samp [0:HD-1];
    logic [NB-1:0] m_level = '0;
    logic [NB-1:0] m_pending = '0;
    logic          m_ovf = 1'b0;
    logic          m_rd_valid = 1'b0;
    logic          m_irq = 1'b0;
    logic [31:0]   m_rd_data = '0;

    initial begin
        for (int j = 0; j < HD; j++) m_samp[j] = '0;
        forever begin
            logic [NB-1:0] nl;
            logic [NB-1:0] pr;
            bit            all_diff;
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int j = 0; j < HD; j++) m_samp[j] = '0;
                m_level = '0; m_pending = '0; m_ovf = 1'b0;
                m_rd_valid = 1'b0; m_irq = 1'b0; m_rd_data = '0;
            end else begin
                for (int j = HD - 1; j > 0; j--) m_samp[j] = m_samp[j-1];
                m_samp[0] = btn;
                nl = m_level;
                for (int b = 0; b < NB; b++) begin
                    all_diff = 1'b1;
                    for (int j = 2; j < HD; j++)
                        if (m_samp[j][b] == m_level[b]) all_diff = 1'b0;
                    if (all_diff) nl[b] = ~m_level[b];
                end
                pr = nl & ~m_level;
                m_irq = |m_pending;
                m_rd_valid = rd_en;
                if (rd_en) begin
                    m_rd_data = {15'b0, m_ovf, 3'b0, m_level, 3'b0, m_pending};
                    m_pending = pr;
                    m_ovf = 1'b0;
                end else begin
                    if (|(pr & m_pending)) m_ovf = 1'b1;
                    m_pending = m_pending | pr;
                end
                m_level = nl;
            end
        end
    end

    logic [38:0] dut_obs, mdl_obs;
    assign dut_obs = {rd_data, rd_valid, btn_level, irq};
    assign mdl_obs = {m_rd_data, m_rd_valid, m_level, m_irq};

    task automatic test_reset();
        rst = 1'b1; btn = '0; rd_en = 1'b0;
        repeat (25) @(negedge clk);
        checks++;
        if (dut_obs !== 39'b0) begin
            errors++; $display("FAIL reset_state got %h required 0", dut_obs);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_obs !== 39'b0) begin
            errors++; $display("FAIL reset_release got %h required 0", dut_obs);
        end
    endtask

    task automatic test_latency();
        int rise = -1;
        int irq_at = -1;
        btn = 5'b00001;
        for (int c = 1; c <= 80; c++) begin
            if (c == 51) btn = '0;
            @(negedge clk);
            checks++;
            if (dut_obs !== mdl_obs) begin
                errors++; $display("FAIL latency_model t=%0t got %h required %h", $time, dut_obs, mdl_obs);
            end
            if (rise < 0 && btn_level[0]) rise = c;
            if (irq_at < 0 && irq) irq_at = c;
        end
        checks++;
        if (rise != 18) begin
            errors++; $display("FAIL latency_rise got %0d required 18", rise);
        end
        checks++;
        if (irq_at != 19) begin
            errors++; $display("FAIL latency_irq got %0d required 19", irq_at);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if ({rd_valid, rd_data, irq} !== {1'b1, 32'h0000_0001, 1'b1}) begin
            errors++; $display("FAIL latency_read got v=%b d=%h irq=%b required v=1 d=00000001 irq=1", rd_valid, rd_data, irq);
        end
        @(negedge clk);
        checks++;
        if ({rd_valid, rd_data, irq} !== {1'b0, 32'h0000_0001, 1'b0}) begin
            errors++; $display("FAIL latency_after_read got v=%b d=%h irq=%b required v=0 d=00000001 irq=0", rd_valid, rd_data, irq);
        end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        for (int c = 0; c < 63; c++) begin
            btn = ((c < 10) || (c >= 13 && c < 23)) ? 5'b10000 : 5'b00000;
            @(negedge clk);
            checks++;
            if (dut_obs !== mdl_obs) begin
                errors++; $display("FAIL glitch_model t=%0t got %h required %h", $time, dut_obs, mdl_obs);
            end
            if (btn_level[4] || irq) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL glitch_reject got level/irq activity required none");
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'h0) begin
            errors++; $display("FAIL glitch_read got %h required 00000000", rd_data);
        end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 180; c++) begin
            btn = (c < 50 || (c >= 100 && c < 150)) ? 5'b01000 : 5'b00000;
            @(negedge clk);
            checks++;
            if (dut_obs !== mdl_obs) begin
                errors++; $display("FAIL overflow_model t=%0t got %h required %h", $time, dut_obs, mdl_obs);
            end
        end
        rd_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, 32'h0001_0008}) begin
            errors++; $display("FAIL overflow_read1 got v=%b d=%h required v=1 d=00010008", rd_valid, rd_data);
        end
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, 32'h0000_0000}) begin
            errors++; $display("FAIL back_to_back_read2 got v=%b d=%h required v=1 d=00000000", rd_valid, rd_data);
        end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_valid_pulse got %b required 0", rd_valid);
        end
    endtask

    task automatic test_simultaneous();
        for (int c = 0; c < 60; c++) begin
            btn = (c < 30) ? 5'b00010 : 5'b00000;
            @(negedge clk);
            checks++;
            if (dut_obs !== mdl_obs) begin
                errors++; $display("FAIL simul_model t=%0t got %h required %h", $time, dut_obs, mdl_obs);
            end
        end
        btn = 5'b00100;
        repeat (17) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if ({rd_data, btn_level} !== {32'h0000_0002, 5'b00100}) begin
            errors++; $display("FAIL simul_read got d=%h lvl=%b required d=00000002 lvl=00100", rd_data, btn_level);
        end
        checks++;
        if (dut_obs !== mdl_obs) begin
            errors++; $display("FAIL simul_model_read got %h required %h", dut_obs, mdl_obs);
        end
        repeat (3) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'h0000_0404) begin
            errors++; $display("FAIL simul_next_read got %h required 00000404", rd_data);
        end
        btn = '0;
        repeat (30) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'h0) begin
            errors++; $display("FAIL simul_clear_read got %h required 00000000", rd_data);
        end
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        btn = 5'b00001;
        repeat (30) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'h0000_0101) begin
            errors++; $display("FAIL rstmid_preread got %h required 00000101", rd_data);
        end
        btn = 5'b00011;
        repeat (12) @(negedge clk);
        #5 rst = 1'b1;
        #1;
        checks++;
        if (dut_obs !== 39'b0) begin
            errors++; $display("FAIL rstmid_async got %h required 0", dut_obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            checks++;
            if (dut_obs !== mdl_obs) begin
                errors++; $display("FAIL rstmid_model t=%0t got %h required %h", $time, dut_obs, mdl_obs);
            end
            if (rise < 0 && btn_level[1]) rise = c;
        end
        checks++;
        if (rise != 18) begin
            errors++; $display("FAIL rstmid_rise got %0d required 18", rise);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (rd_data !== 32'h0000_0303) begin
            errors++; $display("FAIL rstmid_read got %h required 00000303", rd_data);
        end
        btn = '0;
        repeat (30) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_sequence();
        logic [NB-1:0] seq [20] = '{1, 16, 1, 16, 1, 8, 1, 4, 1, 4, 8, 1, 2, 1, 16, 16, 8, 1, 4, 1};
        for (int k = 0; k < 20; k++) begin
            int hold = $urandom_range(20, 60);
            int gap  = $urandom_range(20, 40);
            btn = seq[k];
            for (int c = 0; c < hold + gap; c++) begin
                if (c == hold) btn = '0;
                @(negedge clk);
                checks++;
                if (dut_obs !== mdl_obs) begin
                    errors++; $display("FAIL seq_model k=%0d t=%0t got %h required %h", k, $time, dut_obs, mdl_obs);
                end
            end
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            checks++;
            if (rd_data !== {27'b0, seq[k]}) begin
                errors++; $display("FAIL seq_read k=%0d got %h required %h", k, rd_data, {27'b0, seq[k]});
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                btn  = NB'($urandom);
                hold = $urandom_range(1, 40);
            end
            hold--;
            rd_en = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            checks++;
            if (dut_obs !== mdl_obs) begin
                errors++; $display("FAIL random_model t=%0t got %h required %h", $time, dut_obs, mdl_obs);
            end
        end
        rd_en = 1'b0;
        btn = '0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_overflow();
        test_simultaneous();
        test_reset_mid();
        test_sequence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
